instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage upstream of the instruction ROM: owns the PC, drives the ROM byte address,
//  captures the returned instruction into the IF/ID pipeline register, and applies
//  branch/jump redirects from later stages.
//  Also keeps a saturating count of valid instructions delivered to decode.
// PARAMETERS
//  PC_WIDTH   6   byte-address width of PC and ROM address; PC is word-aligned (bits [1:0]=0)
//  CNT_WIDTH  16  width of Fetch_Count
// PORTS
//  Clk            in   1         rising-edge clock
//  Reset_n        in   1         asynchronous, active-low reset
//  Address        out  PC_WIDTH  current PC to instruction ROM (= PC register, combinational)
//  Instruction    in   32        ROM data for Address, valid same cycle
//  Stall          in   1         hold PC and IF/ID (hazard from decode)
//  Branch_Taken   in   1         redirect to branch target this cycle
//  Branch_Base    in   PC_WIDTH  PC+4 of the branch instruction
//  Branch_Offset  in   16        signed word offset from the branch immediate
//  Jump           in   1         redirect to jump target this cycle
//  Jump_Index     in   26        J-type instr_index field
//  IfId_Instr     out  32        registered instruction to decode
//  IfId_PCPlus4   out  PC_WIDTH  registered PC+4 of IfId_Instr
//  IfId_Valid     out  1         1 = IfId_Instr is a real instruction, 0 = bubble
//  Fetch_Count    out  CNT_WIDTH valid instructions captured since reset
// BEHAVIOUR
//  Reset (async, Reset_n=0): PC=0, IfId_Instr=0, IfId_PCPlus4=0, IfId_Valid=0,
//   Fetch_Count=0, state=BOOT. Reset mid-operation aborts everything immediately.
//  FSM: BOOT -> RUN after exactly one clock edge (unconditional). RUN -> RUN.
//   BOOT edge: PC holds 0, IF/ID remains a bubble, Fetch_Count unchanged.
//   Redirect, Stall and Fetch_Count are acted on only in RUN; in BOOT they are ignored.
//  Targets (all arithmetic modulo 2^PC_WIDTH, carries discarded):
//   branch_tgt = Branch_Base + (sign_extend(Branch_Offset) << 2), truncated to PC_WIDTH
//   jump_tgt   = (Jump_Index << 2) truncated to PC_WIDTH
//   pc_plus4   = PC + 4; wraps from 2^PC_WIDTH-4 to 0
//  Per rising edge in RUN, priority high->low:
//   1 Branch_Taken: PC<=branch_tgt; IF/ID<=bubble (Instr=0, PCPlus4=0, Valid=0)
//   2 Jump:         PC<=jump_tgt;   IF/ID<=bubble
//   3 Stall:        PC, IF/ID and Fetch_Count hold their values
//   4 otherwise:    IfId_Instr<=Instruction, IfId_PCPlus4<=pc_plus4, IfId_Valid<=1,
//                   PC<=pc_plus4, Fetch_Count<=Fetch_Count+1 (saturates at all-ones)
//  Branch_Taken+Jump together: branch wins. A redirect overrides Stall.
//  Latency: ROM access is combinational; an instruction appears on IfId_* one edge after its
//   PC is driven. Every redirect costs exactly one bubble cycle.
//  Fetch_Count increments only on rule 4; bubbles, stalls and redirects never count.
//  Address is never X after reset; Instruction is sampled only on rule-4 edges.
// TESTING
//  T1 reset, release, ROM loaded with program -> BOOT edge: Address=0, Valid=0; next edge:
//     IfId_Instr=8C010010, IfId_PCPlus4=4, Valid=1, Address=4, Fetch_Count=1
//  T2 Branch_Taken=1, Branch_Base=16, Branch_Offset=9 -> next edge Address=52, Valid=0;
//     following edge IfId_Instr=00222020, Valid=1
//  T3 Branch_Base=40, Branch_Offset=16'hFFF6 (-10) -> Address=0; Base=40, Offset=5 -> 60
//  T4 PC=60, Jump=1, Jump_Index=0 -> Address=0, Valid=0; and PC=60 with no redirect -> wraps
//     to 0, IfId_PCPlus4=0, IfId_Instr=08000000
//  T5 Stall=1 for 3 edges at PC=20 -> Address stays 20, IF/ID and Fetch_Count unchanged;
//     Stall=1 with Jump=1, Jump_Index=3 -> Address=12, Valid=0
//  T6 Branch_Taken=1 and Jump=1 same edge -> branch target taken; Reset_n low mid-run ->
//     outputs zero at once without a clock edge; Fetch_Count forced near max saturates

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage. Owns the PC, drives the instruction ROM address,
//               registers the returned word into IF/ID, applies branch/jump
//               redirects and keeps a saturating delivered-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int PC_WIDTH  = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    output logic [PC_WIDTH-1:0]  Address,
    input  logic [31:0]          Instruction,
    input  logic                 Stall,
    input  logic                 Branch_Taken,
    input  logic [PC_WIDTH-1:0]  Branch_Base,
    input  logic [15:0]          Branch_Offset,
    input  logic                 Jump,
    input  logic [25:0]          Jump_Index,
    output logic [31:0]          IfId_Instr,
    output logic [PC_WIDTH-1:0]  IfId_PCPlus4,
    output logic                 IfId_Valid,
    output logic [CNT_WIDTH-1:0] Fetch_Count
);

    // One boot edge after reset, then the pipeline runs forever.
    localparam logic [0:0] c_st_boot = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    localparam logic [PC_WIDTH-1:0] c_four = PC_WIDTH'(4);

    logic [0:0]           r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [31:0]          r_ifid_instr;
    logic [PC_WIDTH-1:0]  r_ifid_pcplus4;
    logic                 r_ifid_valid;
    logic [CNT_WIDTH-1:0] r_fetch_count;

    logic [31:0]          w_branch_ofs32;
    logic [31:0]          w_jump_tgt32;
    logic [PC_WIDTH-1:0]  w_branch_tgt;
    logic [PC_WIDTH-1:0]  w_jump_tgt;
    logic [PC_WIDTH-1:0]  w_pc_plus4;
    logic                 w_run;
    logic                 w_capture;

    // Targets are formed at 32 bits and truncated, so carries out of the PC
    // width simply vanish and everything wraps modulo 2^PC_WIDTH.
    assign w_branch_ofs32 = {{14{Branch_Offset[15]}}, Branch_Offset, 2'b00};
    assign w_jump_tgt32   = {4'b0000, Jump_Index, 2'b00};
    assign w_branch_tgt   = Branch_Base + w_branch_ofs32[PC_WIDTH-1:0];
    assign w_jump_tgt     = w_jump_tgt32[PC_WIDTH-1:0];
    assign w_pc_plus4     = r_pc + c_four;

    assign w_run     = (r_state == c_st_run);
    // A normal sequential fetch: running, no redirect, decode not stalled.
    assign w_capture = w_run && !Branch_Taken && !Jump && !Stall;

    // Boot sequencing: leave BOOT on the first edge after reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_st_boot;
        end else begin
            r_state <= c_st_run;
        end
    end

    // PC and IF/ID register: redirect (branch over jump) beats stall beats fetch.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pc           <= '0;
            r_ifid_instr   <= '0;
            r_ifid_pcplus4 <= '0;
            r_ifid_valid   <= 1'b0;
        end else if (w_run) begin
            if (Branch_Taken) begin
                r_pc           <= w_branch_tgt;
                r_ifid_instr   <= '0;
                r_ifid_pcplus4 <= '0;
                r_ifid_valid   <= 1'b0;
            end else if (Jump) begin
                r_pc           <= w_jump_tgt;
                r_ifid_instr   <= '0;
                r_ifid_pcplus4 <= '0;
                r_ifid_valid   <= 1'b0;
            end else if (!Stall) begin
                r_pc           <= w_pc_plus4;
                r_ifid_instr   <= Instruction;
                r_ifid_pcplus4 <= w_pc_plus4;
                r_ifid_valid   <= 1'b1;
            end
        end
    end

    // Delivered-instruction counter, sticks at all-ones.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fetch_count <= '0;
        end else if (w_capture && !(&r_fetch_count)) begin
            r_fetch_count <= r_fetch_count + 1'b1;
        end
    end

    assign Address      = r_pc;
    assign IfId_Instr   = r_ifid_instr;
    assign IfId_PCPlus4 = r_ifid_pcplus4;
    assign IfId_Valid   = r_ifid_valid;
    assign Fetch_Count  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit: directed scenarios
//               plus randomized traffic against a behavioural fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        Clk;
    logic        Reset_n;
    logic [5:0]  Address;
    logic [31:0] Instruction;
    logic        Stall;
    logic        Branch_Taken;
    logic [5:0]  Branch_Base;
    logic [15:0] Branch_Offset;
    logic        Jump;
    logic [25:0] Jump_Index;
    logic [31:0] IfId_Instr;
    logic [5:0]  IfId_PCPlus4;
    logic        IfId_Valid;
    logic [15:0] Fetch_Count;

    // Narrow-counter copy, used to reach saturation quickly.
    logic [5:0]  s_address;
    logic [31:0] s_instr;
    logic [5:0]  s_pcplus4;
    logic        s_valid;
    logic [3:0]  s_count;

    logic [31:0] rom [16];

    int n_vec;
    int n_err;

    // Behavioural model state
    bit       m_boot;
    int       m_pc;
    int       m_instr;
    int       m_pc4;
    bit       m_valid;
    int       m_cnt;
    int       m_cnt_sat;

    instr_fetch_unit #(.PC_WIDTH(6), .CNT_WIDTH(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Address(Address), .Instruction(Instruction),
        .Stall(Stall), .Branch_Taken(Branch_Taken), .Branch_Base(Branch_Base),
        .Branch_Offset(Branch_Offset), .Jump(Jump), .Jump_Index(Jump_Index),
        .IfId_Instr(IfId_Instr), .IfId_PCPlus4(IfId_PCPlus4), .IfId_Valid(IfId_Valid),
        .Fetch_Count(Fetch_Count)
    );

    instr_fetch_unit #(.PC_WIDTH(6), .CNT_WIDTH(4)) dut_sat (
        .Clk(Clk), .Reset_n(Reset_n), .Address(s_address), .Instruction(rom[s_address[5:2]]),
        .Stall(Stall), .Branch_Taken(Branch_Taken), .Branch_Base(Branch_Base),
        .Branch_Offset(Branch_Offset), .Jump(Jump), .Jump_Index(Jump_Index),
        .IfId_Instr(s_instr), .IfId_PCPlus4(s_pcplus4), .IfId_Valid(s_valid),
        .Fetch_Count(s_count)
    );

    assign Instruction = rom[Address[5:2]];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_boot = 1; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
        m_cnt = 0; m_cnt_sat = 0;
    endtask

    task automatic set_ctl(input bit br, input int base, input int off,
                           input bit jmp, input int idx, input bit st);
        Branch_Taken  = br;
        Branch_Base   = 6'(base);
        Branch_Offset = 16'(off);
        Jump          = jmp;
        Jump_Index    = 26'(idx);
        Stall         = st;
    endtask

    // Advance one clock edge; the model computes the next state from the
    // rules using the inputs present before the edge.
    task automatic step();
        int  nb_pc, nb_instr, nb_pc4, nb_cnt, nb_sat;
        bit  nb_valid;
        int  tgt;
        nb_pc = m_pc; nb_instr = m_instr; nb_pc4 = m_pc4; nb_valid = m_valid;
        nb_cnt = m_cnt; nb_sat = m_cnt_sat;
        if (!m_boot) begin
            if (Branch_Taken) begin
                tgt = int'(Branch_Base) + 4 * int'($signed(Branch_Offset));
                nb_pc = ((tgt % 64) + 64) % 64;
                nb_instr = 0; nb_pc4 = 0; nb_valid = 0;
            end else if (Jump) begin
                nb_pc = int'((64'(Jump_Index) * 4) % 64);
                nb_instr = 0; nb_pc4 = 0; nb_valid = 0;
            end else if (!Stall) begin
                nb_instr = int'(rom[m_pc / 4]);
                nb_pc4   = (m_pc + 4) % 64;
                nb_valid = 1;
                nb_pc    = nb_pc4;
                if (nb_cnt < 65535) nb_cnt = nb_cnt + 1;
                if (nb_sat < 15)    nb_sat = nb_sat + 1;
            end
        end
        @(posedge Clk);
        #1;
        m_boot = 0; m_pc = nb_pc; m_instr = nb_instr; m_pc4 = nb_pc4;
        m_valid = nb_valid; m_cnt = nb_cnt; m_cnt_sat = nb_sat;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        set_ctl(0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        n_vec++;
        if ({Address, IfId_Instr, IfId_PCPlus4, IfId_Valid, Fetch_Count} !== '0) begin
            n_err++;
            $display("FAIL reset_state: addr=%0d instr=%h pc4=%0d valid=%b cnt=%0d, required all zero",
                     Address, IfId_Instr, IfId_PCPlus4, IfId_Valid, Fetch_Count);
        end
        @(posedge Clk); #2;
        Reset_n = 1'b1;
        // Controls asserted during the boot edge must be ignored.
        set_ctl(1, 16, 9, 1, 7, 1);
        step();
        n_vec++;
        if (Address !== 6'd0 || IfId_Valid !== 1'b0 || Fetch_Count !== 16'd0) begin
            n_err++;
            $display("FAIL boot_edge: addr=%0d valid=%b cnt=%0d, required addr=0 valid=0 cnt=0",
                     Address, IfId_Valid, Fetch_Count);
        end
    endtask

    task automatic test_first_fetch();
        set_ctl(0, 0, 0, 0, 0, 0);
        step();
        n_vec++;
        if (IfId_Instr !== 32'h8C010010 || IfId_PCPlus4 !== 6'd4 || IfId_Valid !== 1'b1 ||
            Address !== 6'd4 || Fetch_Count !== 16'd1) begin
            n_err++;
            $display("FAIL first_fetch: instr=%h pc4=%0d valid=%b addr=%0d cnt=%0d, required 8c010010/4/1/4/1",
                     IfId_Instr, IfId_PCPlus4, IfId_Valid, Address, Fetch_Count);
        end
    endtask

    task automatic test_branch();
        set_ctl(1, 16, 9, 0, 0, 0);
        step();
        n_vec++;
        if (Address !== 6'd52 || IfId_Valid !== 1'b0 || IfId_Instr !== 32'd0) begin
            n_err++;
            $display("FAIL branch_redirect: addr=%0d valid=%b instr=%h, required addr=52 valid=0 instr=0",
                     Address, IfId_Valid, IfId_Instr);
        end
        set_ctl(0, 0, 0, 0, 0, 0);
        step();
        n_vec++;
        if (IfId_Instr !== 32'h00222020 || IfId_Valid !== 1'b1 || Fetch_Count !== 16'd2) begin
            n_err++;
            $display("FAIL branch_fetch: instr=%h valid=%b cnt=%0d, required 00222020/1/2",
                     IfId_Instr, IfId_Valid, Fetch_Count);
        end
    endtask

    task automatic test_branch_targets();
        set_ctl(1, 40, 16'hFFF6, 0, 0, 0);
        step();
        n_vec++;
        if (Address !== 6'd0) begin
            n_err++;
            $display("FAIL branch_negative: addr=%0d, required 0", Address);
        end
        set_ctl(1, 40, 5, 0, 0, 0);
        step();
        n_vec++;
        if (Address !== 6'd60) begin
            n_err++;
            $display("FAIL branch_positive: addr=%0d, required 60", Address);
        end
    endtask

    task automatic test_jump_wrap();
        set_ctl(0, 0, 0, 1, 0, 0);
        step();
        n_vec++;
        if (Address !== 6'd0 || IfId_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL jump_zero: addr=%0d valid=%b, required addr=0 valid=0", Address, IfId_Valid);
        end
        set_ctl(0, 0, 0, 1, 15, 0);
        step();
        set_ctl(0, 0, 0, 0, 0, 0);
        step();
        n_vec++;
        if (Address !== 6'd0 || IfId_PCPlus4 !== 6'd0 || IfId_Instr !== 32'h08000000 ||
            IfId_Valid !== 1'b1) begin
            n_err++;
            $display("FAIL pc_wrap: addr=%0d pc4=%0d instr=%h valid=%b, required 0/0/08000000/1",
                     Address, IfId_PCPlus4, IfId_Instr, IfId_Valid);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_instr;
        logic [15:0] held_cnt;
        set_ctl(0, 0, 0, 1, 4, 0);
        step();
        set_ctl(0, 0, 0, 0, 0, 0);
        step();
        held_instr = IfId_Instr;
        held_cnt   = Fetch_Count;
        n_vec++;
        if (Address !== 6'd20 || held_instr !== rom[4]) begin
            n_err++;
            $display("FAIL stall_setup: addr=%0d instr=%h, required 20/%h", Address, held_instr, rom[4]);
        end
        for (int i = 0; i < 3; i++) begin
            set_ctl(0, 0, 0, 0, 0, 1);
            step();
            n_vec++;
            if (Address !== 6'd20 || IfId_Instr !== held_instr || IfId_PCPlus4 !== 6'd20 ||
                IfId_Valid !== 1'b1 || Fetch_Count !== held_cnt) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: addr=%0d instr=%h pc4=%0d valid=%b cnt=%0d, required 20/%h/20/1/%0d",
                         i, Address, IfId_Instr, IfId_PCPlus4, IfId_Valid, Fetch_Count, held_instr, held_cnt);
            end
        end
        set_ctl(0, 0, 0, 1, 3, 1);
        step();
        n_vec++;
        if (Address !== 6'd12 || IfId_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_jump: addr=%0d valid=%b, required 12/0", Address, IfId_Valid);
        end
    endtask

    task automatic test_priority();
        set_ctl(1, 8, 2, 1, 9, 0);
        step();
        n_vec++;
        if (Address !== 6'd16 || IfId_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL branch_over_jump: addr=%0d valid=%b, required 16/0", Address, IfId_Valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_ctl($urandom_range(0, 9) == 0, int'($urandom_range(0, 15)) * 4, int'($urandom()),
                    $urandom_range(0, 9) == 0, int'($urandom()), $urandom_range(0, 3) == 0);
            step();
            n_vec++;
            if (Address !== 6'(m_pc) || IfId_Instr !== 32'(m_instr) || IfId_PCPlus4 !== 6'(m_pc4) ||
                IfId_Valid !== m_valid || Fetch_Count !== 16'(m_cnt) || s_count !== 4'(m_cnt_sat)) begin
                n_err++;
                $display("FAIL random[%0d]: addr=%0d instr=%h pc4=%0d valid=%b cnt=%0d sat=%0d, required %0d/%h/%0d/%b/%0d/%0d",
                         i, Address, IfId_Instr, IfId_PCPlus4, IfId_Valid, Fetch_Count, s_count,
                         m_pc, m_instr, m_pc4, m_valid, m_cnt, m_cnt_sat);
            end
        end
    endtask

    task automatic test_saturate();
        set_ctl(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step();
        n_vec++;
        if (s_count !== 4'hF || m_cnt_sat != 15) begin
            n_err++;
            $display("FAIL count_saturate: cnt=%0d, required 15", s_count);
        end
        n_vec++;
        if (Fetch_Count !== 16'(m_cnt)) begin
            n_err++;
            $display("FAIL count_wide: cnt=%0d, required %0d", Fetch_Count, m_cnt);
        end
    endtask

    task automatic test_async_reset();
        set_ctl(0, 0, 0, 0, 0, 0);
        step();
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({Address, IfId_Instr, IfId_PCPlus4, IfId_Valid, Fetch_Count, s_count} !== '0) begin
            n_err++;
            $display("FAIL async_reset: addr=%0d instr=%h pc4=%0d valid=%b cnt=%0d sat=%0d, required all zero",
                     Address, IfId_Instr, IfId_PCPlus4, IfId_Valid, Fetch_Count, s_count);
        end
        @(posedge Clk); #2;
        Reset_n = 1'b1;
        step();
        step();
        n_vec++;
        if (Address !== 6'd4 || IfId_Instr !== 32'h8C010010 || Fetch_Count !== 16'd1) begin
            n_err++;
            $display("FAIL restart: addr=%0d instr=%h cnt=%0d, required 4/8c010010/1",
                     Address, IfId_Instr, Fetch_Count);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) rom[i] = $urandom();
        rom[0]  = 32'h8C010010;
        rom[13] = 32'h00222020;
        rom[15] = 32'h08000000;
        test_reset();
        test_first_fetch();
        test_branch();
        test_branch_targets();
        test_jump_wrap();
        test_stall();
        test_priority();
        test_random();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
